// File: rtl/ipv4_udp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ipv4_udp_tx
//  Purpose  : Transmit-side UDP/IPv4 header generator. On the start beat of an
//             application frame it emits a 28-byte IPv4+UDP header, then
//             cut-through forwards the payload to the MAC stage unchanged.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             app_*               - payload stream in (valid/ready, start,
//                                   last, data, len, pld_len, cancel)
//             mac_*               - header+payload stream out (valid/ready,
//                                   start, last, data, len, cancel)
//             err_o               - pulse on rejected or malformed frame
//  Options  : TX_LEN_CHECK_EN     - when defined, counts forwarded payload
//                                   bytes and aborts the frame if the count
//                                   disagrees with the declared length
//  Notes    : DATA_W must be 16 or 32 so the header is a whole number of beats.
//  Revision : 1.0 - initial release
// ============================================================================
module ipv4_udp_tx #(
    parameter int          DATA_W      = 16,
    parameter int          LEN_W       = $clog2(DATA_W/8 + 1),
    parameter logic [31:0] IP_SRC_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [31:0] IP_DST_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [15:0] SRC_PORT    = 16'd18070,
    parameter logic [15:0] DST_PORT    = 16'd18070,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int          MAX_PLD     = 1472
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              app_valid_i,
    output logic              app_ready_o,
    input  logic              app_start_i,
    input  logic              app_last_i,
    input  logic [DATA_W-1:0] app_data_i,
    input  logic [LEN_W-1:0]  app_len_i,
    input  logic [15:0]       app_pld_len_i,
    input  logic              app_cancel_i,
    output logic              mac_valid_o,
    input  logic              mac_ready_i,
    output logic              mac_start_o,
    output logic              mac_last_o,
    output logic [DATA_W-1:0] mac_data_o,
    output logic [LEN_W-1:0]  mac_len_o,
    output logic              mac_cancel_o,
    output logic              err_o
);

    localparam int c_KEEP_W    = DATA_W / 8;
    localparam int c_HDR_BEATS = 28 / c_KEEP_W;
    localparam int c_BEAT_W    = $clog2(c_HDR_BEATS);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_HDR_BEATS - 1);
    localparam logic [LEN_W-1:0]    c_FULL_LEN  = LEN_W'(c_KEEP_W);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_PLD  = 2'd2;
    localparam logic [1:0] c_DROP = 2'd3;

    // Header words that never change, pre-summed so only length and ID are
    // added at run time. 20 bits hold the worst-case sum of nine 16-bit words.
    localparam logic [19:0] c_CONST_SUM =
        20'h04500 + 20'h04000 + {4'h0, TTL, 8'h11} +
        {4'h0, IP_SRC_ADDR[31:16]} + {4'h0, IP_SRC_ADDR[15:0]} +
        {4'h0, IP_DST_ADDR[31:16]} + {4'h0, IP_DST_ADDR[15:0]};

    logic [1:0]          r_state, w_next;
    logic [c_BEAT_W-1:0] r_beat;
    logic [15:0]         r_len, r_id, r_csum;

    logic                w_start_seen, w_bad_len, w_hdr_fire, w_pld_last, w_len_err;
    logic [15:0]         w_tot_len;
    logic [19:0]         w_sum;
    logic [16:0]         w_fold1;
    logic [15:0]         w_fold2, w_csum;
    logic [223:0]        w_hdr;
    logic [DATA_W-1:0]   w_beats [c_HDR_BEATS];

    assign w_start_seen = app_valid_i & app_start_i;
    assign w_bad_len    = (app_pld_len_i == 16'd0) || (app_pld_len_i > 16'(MAX_PLD));
    assign w_hdr_fire   = (r_state == c_HDR) & mac_ready_i;
    // Cancel takes priority over completion, so a cancelled last beat never
    // bumps the ID.
    assign w_pld_last   = (r_state == c_PLD) & app_valid_i & mac_ready_i &
                          app_last_i & ~app_cancel_i;

    // Checksum from the incoming length and the current ID; registered on the
    // start beat so the header stays stable for the whole HDR phase.
    assign w_tot_len = app_pld_len_i + 16'd28;
    assign w_sum     = c_CONST_SUM + {4'h0, w_tot_len} + {4'h0, r_id};
    assign w_fold1   = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
    assign w_fold2   = w_fold1[15:0] + {15'd0, w_fold1[16]};
    assign w_csum    = ~w_fold2;

    assign w_hdr = {16'h4500, r_len + 16'd28, r_id,
                    16'h4000, TTL, 8'h11, r_csum,
                    IP_SRC_ADDR, IP_DST_ADDR,
                    SRC_PORT, DST_PORT, r_len + 16'd8, 16'h0000};

    for (genvar g = 0; g < c_HDR_BEATS; g++) begin : g_beat
        assign w_beats[g] = w_hdr[223 - g*DATA_W -: DATA_W];
    end

`ifdef TX_LEN_CHECK_EN
    logic [15:0] r_cnt, w_cnt_next;

    assign w_cnt_next = r_cnt + 16'(mac_len_o);
    assign w_len_err  = w_pld_last & (w_cnt_next != r_len);

    always_ff @(posedge clk) begin
        if (reset || r_state != c_PLD) begin
            r_cnt <= 16'd0;
        end else if (app_valid_i && mac_ready_i) begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    assign w_len_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (w_start_seen) w_next = w_bad_len ? c_DROP : c_HDR;
            c_HDR: begin
                if (app_cancel_i)                             w_next = c_IDLE;
                else if (w_hdr_fire && r_beat == c_LAST_BEAT) w_next = c_PLD;
            end
            c_PLD: begin
                if (app_cancel_i)    w_next = c_IDLE;
                else if (w_pld_last) w_next = c_IDLE;
            end
            default: if (app_valid_i && app_last_i) w_next = c_IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is asserted.
    always_comb begin
        app_ready_o  = 1'b0;
        mac_valid_o  = 1'b0;
        mac_start_o  = 1'b0;
        mac_last_o   = 1'b0;
        mac_data_o   = '0;
        mac_len_o    = '0;
        mac_cancel_o = 1'b0;
        err_o        = 1'b0;
        case (r_state)
            c_IDLE: err_o = w_start_seen & w_bad_len;
            c_HDR: begin
                mac_valid_o  = 1'b1;
                mac_start_o  = (r_beat == '0);
                mac_data_o   = w_beats[r_beat];
                mac_len_o    = c_FULL_LEN;
                mac_cancel_o = app_cancel_i;
            end
            c_PLD: begin
                mac_valid_o  = app_valid_i;
                app_ready_o  = mac_ready_i;
                mac_data_o   = app_data_i;
                mac_len_o    = app_last_i ? app_len_i : c_FULL_LEN;
                mac_last_o   = app_last_i;
                mac_cancel_o = app_cancel_i | w_len_err;
                err_o        = w_len_err;
            end
            default: app_ready_o = 1'b1;
        endcase
        if (reset) begin
            app_ready_o  = 1'b0;
            mac_valid_o  = 1'b0;
            mac_start_o  = 1'b0;
            mac_last_o   = 1'b0;
            mac_data_o   = '0;
            mac_len_o    = '0;
            mac_cancel_o = 1'b0;
            err_o        = 1'b0;
        end
    end

    // Frame bookkeeping: header beat counter, latched length/checksum, ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat <= '0;
            r_len  <= 16'd0;
            r_csum <= 16'd0;
            r_id   <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_beat <= '0;
                    if (w_start_seen && !w_bad_len) begin
                        r_len  <= app_pld_len_i;
                        r_csum <= w_csum;
                    end
                end
                c_HDR: if (w_hdr_fire && !app_cancel_i) r_beat <= r_beat + 1'b1;
                c_PLD: if (w_pld_last && !w_len_err) r_id <= r_id + 16'd1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ipv4_udp_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ipv4_udp_tx
//  Purpose  : Directed self-checking bench for ipv4_udp_tx (DATA_W=16).
//             Covers reset, single frame, consecutive frames, MAC stalls,
//             illegal lengths, cancel, and (with TX_LEN_CHECK_EN) the
//             payload length check.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ipv4_udp_tx;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              app_valid_i, app_start_i, app_last_i, app_cancel_i;
    logic              app_ready_o;
    logic [DATA_W-1:0] app_data_i;
    logic [LEN_W-1:0]  app_len_i;
    logic [15:0]       app_pld_len_i;
    logic              mac_valid_o, mac_ready_i, mac_start_o, mac_last_o;
    logic [DATA_W-1:0] mac_data_o;
    logic [LEN_W-1:0]  mac_len_o;
    logic              mac_cancel_o, err_o;

    always #5 clk = ~clk;

    ipv4_udp_tx #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .app_valid_i(app_valid_i), .app_ready_o(app_ready_o),
        .app_start_i(app_start_i), .app_last_i(app_last_i),
        .app_data_i(app_data_i), .app_len_i(app_len_i),
        .app_pld_len_i(app_pld_len_i), .app_cancel_i(app_cancel_i),
        .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i),
        .mac_start_o(mac_start_o), .mac_last_o(mac_last_o),
        .mac_data_o(mac_data_o), .mac_len_o(mac_len_o),
        .mac_cancel_o(mac_cancel_o), .err_o(err_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: collects accepted bytes and event timestamps.
    logic [7:0]  rx_q[$];
    int          n_beats = 0, t_hdr = 0, t_pld = 0, t_last = 0, t_canc = 0, t_errp = 0;
    int          n_errp = 0, n_canc = 0, n_valid = 0, n_unstable = 0, last_len = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    always @(negedge clk) begin
        if (prev_stall && mac_valid_o && mac_data_o !== prev_data) n_unstable++;
        prev_stall = mac_valid_o & ~mac_ready_i;
        prev_data  = mac_data_o;
        if (mac_valid_o) n_valid++;
        if (err_o) begin n_errp++; t_errp = cyc; end
        if (mac_cancel_o) begin n_canc++; t_canc = cyc; end
        if (mac_valid_o && mac_ready_i) begin
            if (mac_start_o) begin n_beats = 0; t_hdr = cyc; end
            if (n_beats == 14) t_pld = cyc;
            for (int k = 0; k < int'(mac_len_o); k++) rx_q.push_back(mac_data_o[15-8*k -: 8]);
            if (mac_last_o) begin t_last = cyc; last_len = int'(mac_len_o); end
            n_beats++;
        end
    end

    function automatic logic [7:0] pbyte(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Drives one application frame; optional random MAC backpressure.
    task automatic drive_frame(input int decl, input int nbytes, input bit stall,
                               output int t_start, output bit ok);
        int nb;
        int guard;
        bit acc;
        nb = (nbytes + 1) / 2;
        ok = 1'b1;
        t_start = -1;
        for (int b = 0; b < nb; b++) begin
            app_valid_i   = 1'b1;
            app_start_i   = (b == 0);
            app_last_i    = (b == nb - 1);
            app_pld_len_i = 16'(decl);
            app_data_i    = {pbyte(2*b), pbyte(2*b + 1)};
            app_len_i     = (b == nb - 1) ? LEN_W'(nbytes - 2*b) : LEN_W'(2);
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 400) begin
                @(negedge clk);
                if (t_start < 0) t_start = cyc;
                acc = app_ready_o;
                @(posedge clk); #1;
                if (stall) mac_ready_i = 1'($urandom_range(0, 1));
                guard++;
            end
            if (!acc) begin ok = 1'b0; break; end
        end
        app_valid_i = 1'b0;
        app_start_i = 1'b0;
        app_last_i  = 1'b0;
        mac_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        app_valid_i = 1'b1; app_start_i = 1'b1; app_pld_len_i = 16'd18;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({app_ready_o, mac_valid_o, mac_start_o, mac_last_o, mac_cancel_o, err_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {app_ready_o, mac_valid_o, mac_start_o, mac_last_o, mac_cancel_o, err_o});
        end
        n_cmp++;
        if (mac_data_o !== 16'h0 || mac_len_o !== 2'd0) begin
            n_err++;
            $display("FAIL reset_data: got data %h len %0d want 0000/0", mac_data_o, mac_len_o);
        end
        @(posedge clk); #1;
        app_valid_i = 1'b0; app_start_i = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mac_valid_o !== 1'b0 || app_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got valid %b ready %b want 0 0", mac_valid_o, app_ready_o);
        end
        @(posedge clk); #1;
    endtask

    // One legal 18-byte frame; checks every output byte against the
    // hand-computed header plus payload pattern.
    task automatic test_frame(input string name, input logic [15:0] id,
                              input logic [15:0] csum, input bit stall);
        logic [15:0] w [14];
        logic [7:0]  exp_b, got_b;
        int ts, e0, c0, u0;
        bit ok;
        w = '{16'h4500, 16'h002E, 16'h0000, 16'h4000, 16'h4011, 16'h0000, 16'hCEC8,
              16'h7F80, 16'hCEC8, 16'h7F80, 16'h4696, 16'h4696, 16'h001A, 16'h0000};
        w[2] = id;
        w[5] = csum;
        rx_q.delete();
        e0 = n_errp; c0 = n_canc; u0 = n_unstable; last_len = -1;
        drive_frame(18, 18, stall, ts, ok);
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s_timeout: payload not accepted within bound", name); end
        n_cmp++;
        if (rx_q.size() != 46) begin
            n_err++; $display("FAIL %s_size: got %0d bytes want 46", name, rx_q.size());
        end
        for (int i = 0; i < 46; i++) begin
            exp_b = (i < 28) ? ((i % 2 == 0) ? w[i/2][15:8] : w[i/2][7:0]) : pbyte(i - 28);
            got_b = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++;
            if (got_b !== exp_b) begin
                n_err++; $display("FAIL %s_byte%0d: got %h want %h", name, i, got_b, exp_b);
            end
        end
        n_cmp++;
        if (last_len != 2) begin n_err++; $display("FAIL %s_last_len: got %0d want 2", name, last_len); end
        n_cmp++;
        if (n_errp != e0 || n_canc != c0) begin
            n_err++; $display("FAIL %s_pulses: got err %0d cancel %0d want 0 0", name, n_errp - e0, n_canc - c0);
        end
        n_cmp++;
        if (n_unstable != u0) begin
            n_err++; $display("FAIL %s_stable: got %0d changes while stalled want 0", name, n_unstable - u0);
        end
        if (!stall) begin
            n_cmp++;
            if (t_hdr - ts != 1) begin n_err++; $display("FAIL %s_hdr_lat: got %0d want 1", name, t_hdr - ts); end
            n_cmp++;
            if (t_pld - ts != 15) begin n_err++; $display("FAIL %s_pld_lat: got %0d want 15", name, t_pld - ts); end
        end
    endtask

    task automatic test_back_to_back();
        test_frame("frame0", 16'h0000, 16'h9E2D, 1'b0);
        test_frame("frame1", 16'h0001, 16'h9E2C, 1'b0);
    endtask

    task automatic test_stall();
        test_frame("stall", 16'h0002, 16'h9E2B, 1'b1);
    endtask

    task automatic test_bad_len(input string name, input int decl);
        int ts, e0, v0;
        bit ok;
        e0 = n_errp; v0 = n_valid;
        drive_frame(decl, 18, 1'b0, ts, ok);
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s_consume: payload not fully consumed", name); end
        n_cmp++;
        if (n_errp - e0 != 1) begin n_err++; $display("FAIL %s_err: got %0d pulses want 1", name, n_errp - e0); end
        n_cmp++;
        if (t_errp != ts) begin n_err++; $display("FAIL %s_err_time: got cycle %0d want %0d", name, t_errp, ts); end
        n_cmp++;
        if (n_valid != v0) begin n_err++; $display("FAIL %s_novalid: got %0d valid cycles want 0", name, n_valid - v0); end
    endtask

    task automatic test_cancel();
        int c0, guard;
        c0 = n_canc;
        n_beats = -100;
        app_valid_i = 1'b1; app_start_i = 1'b1; app_last_i = 1'b0;
        app_pld_len_i = 16'd18; app_data_i = {pbyte(0), pbyte(1)}; app_len_i = 2'd2;
        guard = 0;
        while (n_beats != 5 && guard < 50) begin @(posedge clk); #1; guard++; end
        n_cmp++;
        if (n_beats != 5) begin n_err++; $display("FAIL cancel_reach: got %0d beats want 5", n_beats); end
        app_cancel_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mac_data_o !== 16'h9E29) begin n_err++; $display("FAIL cancel_beat5: got %h want 9e29", mac_data_o); end
        n_cmp++;
        if (mac_cancel_o !== 1'b1) begin n_err++; $display("FAIL cancel_pulse: got %b want 1", mac_cancel_o); end
        @(posedge clk); #1;
        app_cancel_i = 1'b0; app_valid_i = 1'b0; app_start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mac_valid_o !== 1'b0 || mac_cancel_o !== 1'b0) begin
            n_err++; $display("FAIL cancel_idle: got valid %b cancel %b want 0 0", mac_valid_o, mac_cancel_o);
        end
        n_cmp++;
        if (n_canc - c0 != 1) begin n_err++; $display("FAIL cancel_count: got %0d want 1", n_canc - c0); end
        @(posedge clk); #1;
        test_frame("after_cancel", 16'h0004, 16'h9E29, 1'b0);
    endtask

`ifdef TX_LEN_CHECK_EN
    task automatic test_len_check();
        int ts, e0, c0;
        bit ok;
        e0 = n_errp; c0 = n_canc;
        drive_frame(18, 20, 1'b0, ts, ok);
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL lenchk_consume: payload not accepted"); end
        n_cmp++;
        if (n_canc - c0 != 1 || n_errp - e0 != 1) begin
            n_err++; $display("FAIL lenchk_pulses: got cancel %0d err %0d want 1 1", n_canc - c0, n_errp - e0);
        end
        n_cmp++;
        if (t_canc != t_last || t_errp != t_last) begin
            n_err++; $display("FAIL lenchk_time: got cancel %0d err %0d want last %0d", t_canc, t_errp, t_last);
        end
        test_frame("after_lenchk", 16'h0005, 16'h9E28, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1;
        app_valid_i = 1'b0; app_start_i = 1'b0; app_last_i = 1'b0; app_cancel_i = 1'b0;
        app_data_i = '0; app_len_i = '0; app_pld_len_i = '0;
        mac_ready_i = 1'b1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_bad_len("oversize", 1500);
        test_bad_len("zero_len", 0);
        test_frame("after_err", 16'h0003, 16'h9E2A, 1'b0);
        test_cancel();
`ifdef TX_LEN_CHECK_EN
        test_len_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ipv4_udp_tx.md
# ipv4_udp_tx

Transmit-side UDP/IPv4 header generator. It accepts an application payload stream and emits a 28-byte IPv4 and UDP header followed by the unmodified payload. The output feeds the MAC transmit stage, which adds the Ethernet header and CRC. The block mirrors the receive stack: it uses the same fixed address, port and protocol configuration, and it cut-through forwards the payload for low latency.

## Interface
Parameters:
- `DATA_W`, 16: bus width. Legal values are 16 and 32 only, because 28 must divide into whole beats. `KEEP_W = DATA_W/8`.
- `LEN_W`, `$clog2(KEEP_W+1)`: width of the valid-byte count on the last beat.
- `IP_SRC_ADDR`, `{206,200,127,128}`: IPv4 source address.
- `IP_DST_ADDR`, `{206,200,127,128}`: IPv4 destination address.
- `SRC_PORT`, 18070: UDP source port.
- `DST_PORT`, 18070: UDP destination port.
- `TTL`, 64: IPv4 time-to-live.
- `MAX_PLD`, 1472: largest legal payload in bytes.

Ports:
- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high reset.
- `app_valid_i`, in, 1: a payload beat is valid.
- `app_ready_o`, out, 1: the block accepts the payload beat.
- `app_start_i`, in, 1: marks the first payload beat.
- `app_last_i`, in, 1: marks the last payload beat.
- `app_data_i`, in, DATA_W: payload data. Byte 0 is in the MSBs.
- `app_len_i`, in, LEN_W: valid bytes on the last beat.
- `app_pld_len_i`, in, 16: payload byte count. Sampled with `app_start_i`.
- `app_cancel_i`, in, 1: abort the current frame.
- `mac_valid_o`, out, 1: output beat is valid.
- `mac_ready_i`, in, 1: the MAC accepts the output beat.
- `mac_start_o`, out, 1: marks the first header beat.
- `mac_last_o`, out, 1: marks the last payload beat.
- `mac_data_o`, out, DATA_W: output data.
- `mac_len_o`, out, LEN_W: valid bytes. Equals KEEP_W on all beats except the last.
- `mac_cancel_o`, out, 1: one-cycle pulse that tells the MAC to abort the frame.
- `err_o`, out, 1: one-cycle pulse for a rejected or malformed frame.

## Operation
States are IDLE, HDR, PLD and DROP.

IDLE:
- `app_ready_o` is 0.
- The input beat is never consumed in IDLE.
- On `app_valid_i & app_start_i`:
  - If `app_pld_len_i` is 0 or greater than `MAX_PLD`, pulse `err_o` and go to DROP.
  - Otherwise latch the length, register the header checksum and go to HDR.

HDR:
- Send `28/KEEP_W` header beats from a beat counter. Send 14 beats when DATA_W=16 and 7 beats when DATA_W=32.
- Advance only when `mac_valid_o & mac_ready_i`.
- Header contents in byte order:
  - `45 00`, then total length `28+pld`, then ID.
  - `40 00` (DF set), then `TTL`, then `11`, then the header checksum.
  - Source address, then destination address.
  - `SRC_PORT`, then `DST_PORT`, then UDP length `8+pld`, then UDP checksum `0000`.
- Go to PLD after the final header beat is accepted.

PLD:
- Combinational pass-through:
  - `mac_valid_o = app_valid_i`.
  - `app_ready_o = mac_ready_i`.
  - `mac_data_o` and `mac_len_o` carry the application data and length.
  - `mac_last_o = app_last_i`.
- The ID increments modulo 2^16 on the accepted last beat, then go to IDLE.

DROP:
- `app_ready_o` is 1 and the payload is consumed with no output.
- Go to IDLE after the accepted last beat.

Checksum:
- The one's-complement sum of the ten 16-bit header words, with the checksum word taken as 0.
- The constant words fold at elaboration.
- Computed from `app_pld_len_i` and the ID while in IDLE, with end-around carry folded twice, then inverted.

Cancel (`app_cancel_i` in HDR or PLD):
- Pulse `mac_cancel_o` in the same cycle.
- Go to IDLE. The ID does not increment.
- `app_cancel_i` is ignored in IDLE and DROP.

`app_start_i` while in HDR, PLD or DROP is ignored as a start.

Reset:
- All outputs go to 0. The ID goes to 0. The state goes to IDLE.
- Reset mid-frame truncates the frame silently. No cancel pulse is produced.

## Timing
- First header beat: `mac_valid_o` rises the cycle after `app_valid_i & app_start_i` is seen in IDLE.
- Minimum cycles from start to the first payload beat on the MAC bus: `1 + 28/KEEP_W`, given no backpressure.
- Payload latency: 0 cycles (combinational).
- Inter-frame gap: at least 1 IDLE cycle.
- `mac_data_o` must stay stable while `mac_valid_o & !mac_ready_i`.

## Configuration
- With `TX_LEN_CHECK_EN` defined:
  - A 16-bit byte counter accumulates accepted `mac_len_o` in PLD.
  - If the count on the last beat differs from the latched length, drive `mac_last_o` normally and pulse both `mac_cancel_o` and `err_o` in the same cycle.
  - The ID does not increment on such a frame.
- Without the macro: no counter, and the last beat always completes the frame.

## Test plan
- 18-byte payload, DATA_W=16, default parameters, ID 0 → header words `4500 002E 0000 4000 4011 9E2D CEC8 7F80 CEC8 7F80 4696 4696 001A 0000`, then 9 payload beats, last beat with `mac_len_o`=2.
- Two consecutive frames → the second frame's ID is `0001` and its checksum is `9E2C`.
- Random `mac_ready_i` stalls in HDR and PLD → byte stream identical to the no-stall run, and data held stable while stalled.
- `app_pld_len_i`=1500 → `err_o` pulses once, no `mac_valid_o`, payload fully consumed, next frame normal.
- `app_cancel_i` at header beat 5 → `mac_cancel_o` pulses, return to IDLE, ID unchanged.
- With `TX_LEN_CHECK_EN`, declared 18 bytes but 20 sent → `mac_cancel_o` and `err_o` pulse on the last beat.
